// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one line-wide memory bus between instruction and data caches.
// Define BUS_ARB_ROUND_ROBIN_EN to alternate simultaneous grants; default gives the data cache fixed priority.
module bus_arbiter #(
  parameter int BUS_ADDRESS_WIDTH = 20,
  parameter int BUS_DATA_WIDTH_SHIFT = 4,
  localparam int W = (2**BUS_DATA_WIDTH_SHIFT)*8,
  localparam int A = BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ic_req_i,
  input  logic [A-1:0] ic_addr_i,
  output logic         ic_done_o,
  output logic [W-1:0] ic_data_o,
  input  logic         dc_req_i,
  input  logic         dc_we_i,
  input  logic [A-1:0] dc_addr_i,
  input  logic [W-1:0] dc_wdata_i,
  output logic         dc_done_o,
  output logic [W-1:0] dc_data_o,
  output logic         bus_req_o,
  output logic [A-1:0] bus_addr_o,
  output logic [W-1:0] bus_data_o,
  output logic         bus_we_o,
  input  logic [W-1:0] bus_data_i,
  input  logic         bus_valid_i
);
  typedef enum logic [1:0] {IDLE, GRANT_IC, GRANT_DC} state_t;
  state_t state, state_n;
  logic [A-1:0] addr_q;
  logic [W-1:0] wdata_q;
  logic we_q, dc_win, start;
`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic rr;
  // rr set means the data cache wins the next tie
  assign dc_win = dc_req_i && (!ic_req_i || rr);
`else
  assign dc_win = dc_req_i;
`endif
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (dc_win ? GRANT_DC : ic_req_i ? GRANT_IC : IDLE)
                            : (bus_valid_i ? IDLE : state);
  end
  assign start = state == IDLE && state_n != IDLE;
  assign bus_req_o = state != IDLE;
  assign bus_addr_o = addr_q;
  assign bus_we_o = state == GRANT_DC && we_q;
  assign bus_data_o = bus_we_o ? wdata_q : '0;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      ic_done_o <= 1'b0;
      dc_done_o <= 1'b0;
      ic_data_o <= '0;
      dc_data_o <= '0;
    end else begin
      state <= state_n;
      ic_done_o <= state == GRANT_IC && bus_valid_i;
      dc_done_o <= state == GRANT_DC && bus_valid_i;
      if (start) begin
        addr_q <= dc_win ? dc_addr_i : ic_addr_i;
        we_q <= dc_win && dc_we_i;
        wdata_q <= dc_win && dc_we_i ? dc_wdata_i : '0;
      end
      if (state == GRANT_IC && bus_valid_i) ic_data_o <= bus_data_i;
      if (state == GRANT_DC && bus_valid_i && !we_q) dc_data_o <= bus_data_i;
    end
  end
`ifdef BUS_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rr <= 1'b0;
    else if (start) rr <= !dc_win;
  end
`endif
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter.
module tb_bus_arbiter;
  localparam int A = 16;
  localparam int W = 128;
  logic clk = 1'b0, rst = 1'b0;
  logic ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, bus_valid = 1'b0;
  logic [A-1:0] ic_addr = '0, dc_addr = '0, bus_addr;
  logic [W-1:0] dc_wdata = '0, bus_rdata = '0, ic_data, dc_data, bus_wdata;
  logic ic_done, dc_done, bus_req, bus_we;
  int checks = 0, errors = 0;
  localparam logic [W-1:0] BEEF = 128'hCAFEF00D_00000000_11112222_DEADBEEF;
  localparam logic [W-1:0] WLINE = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
  localparam logic [W-1:0] DLINE = 128'hA5A5A5A5_5A5A5A5A_00FF00FF_C0FFEE00;

  bus_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .ic_req_i(ic_req), .ic_addr_i(ic_addr), .ic_done_o(ic_done), .ic_data_o(ic_data),
    .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
    .dc_done_o(dc_done), .dc_data_o(dc_data),
    .bus_req_o(bus_req), .bus_addr_o(bus_addr), .bus_data_o(bus_wdata), .bus_we_o(bus_we),
    .bus_data_i(bus_rdata), .bus_valid_i(bus_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic all_zero(input string tag);
    check({tag, " req"}, W'(bus_req), '0);
    check({tag, " addr"}, W'(bus_addr), '0);
    check({tag, " we"}, W'(bus_we), '0);
    check({tag, " wdata"}, bus_wdata, '0);
    check({tag, " dones"}, W'({ic_done, dc_done}), '0);
    check({tag, " ic_data"}, ic_data, '0);
    check({tag, " dc_data"}, dc_data, '0);
  endtask

  initial begin
    tick();
    all_zero("reset");
    rst = 1'b1;
    // IC read, dropping the request mid-transaction, valid 3 cycles after bus_req
    ic_req = 1'b1; ic_addr = 16'h0040;
    tick();
    check("ic grant req", W'(bus_req), 1);
    check("ic grant addr", W'(bus_addr), 16'h0040);
    check("ic grant we", W'(bus_we), 0);
    check("ic grant wdata", bus_wdata, '0);
    ic_req = 1'b0; ic_addr = 16'h7777;
    tick();
    check("ic wait addr", W'(bus_addr), 16'h0040);
    check("ic wait done", W'(ic_done), 0);
    tick();
    bus_valid = 1'b1; bus_rdata = BEEF;
    tick();
    bus_valid = 1'b0; bus_rdata = '0;
    check("ic done pulse", W'(ic_done), 1);
    check("ic data", ic_data, BEEF);
    check("ic back idle", W'(bus_req), 0);
    tick();
    check("ic done once", W'(ic_done), 0);
    check("ic data held", ic_data, BEEF);
    check("ic no regrant", W'(bus_req), 0);
    // DC write of all-ones address
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 16'hFFFF; dc_wdata = WLINE;
    tick();
    check("dcw addr", W'(bus_addr), 16'hFFFF);
    check("dcw wdata", bus_wdata, WLINE);
    check("dcw we", W'(bus_we), 1);
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = 16'h0001; dc_wdata = '1;
    tick();
    check("dcw addr stable", W'(bus_addr), 16'hFFFF);
    check("dcw wdata stable", bus_wdata, WLINE);
    bus_valid = 1'b1; bus_rdata = DLINE;
    tick();
    bus_valid = 1'b0;
    check("dcw done", W'(dc_done), 1);
    check("dcw dc_data kept", dc_data, '0);
    check("dcw we off", W'(bus_we), 0);
    check("dcw wdata off", bus_wdata, '0);
    // DC read
    dc_req = 1'b1; dc_addr = 16'h0123;
    tick();
    dc_req = 1'b0;
    check("dcr we", W'(bus_we), 0);
    check("dcr addr", W'(bus_addr), 16'h0123);
    bus_valid = 1'b1; bus_rdata = DLINE;
    tick();
    bus_valid = 1'b0;
    check("dcr done", W'({ic_done, dc_done}), 2'b01);
    check("dcr data", dc_data, DLINE);
    check("dcr ic_data kept", ic_data, BEEF);
    // Both requests held for four transactions
    ic_req = 1'b1; ic_addr = 16'h1111; dc_req = 1'b1; dc_addr = 16'h2222;
    tick();
    for (int i = 0; i < 4; i++) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      logic is_dc = i[0];
`else
      logic is_dc = 1'b1;
`endif
      check($sformatf("arb%0d req", i), W'(bus_req), 1);
      check($sformatf("arb%0d owner", i), W'(bus_addr), is_dc ? 16'h2222 : 16'h1111);
      bus_valid = 1'b1; bus_rdata = W'(i + 100);
      tick();
      bus_valid = 1'b0;
      check($sformatf("arb%0d done", i), W'({ic_done, dc_done}), is_dc ? 2'b01 : 2'b10);
      if (i == 3) begin ic_req = 1'b0; dc_req = 1'b0; end
      tick();
    end
    check("arb idle", W'(bus_req), 0);
    // Reset during GRANT_DC
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 16'h0BAD; dc_wdata = WLINE;
    tick();
    check("rst pre grant", W'(bus_req), 1);
    dc_req = 1'b0; dc_we = 1'b0;
    #2 rst = 1'b0;
    #1 all_zero("async rst");
    bus_valid = 1'b1;
    tick();
    check("rst no done", W'(dc_done), 0);
    check("rst still idle", W'(bus_req), 0);
    rst = 1'b1; bus_valid = 1'b0;
    ic_req = 1'b1; ic_addr = 16'h0042;
    tick();
    check("post rst grant", W'(bus_req), 1);
    check("post rst addr", W'(bus_addr), 16'h0042);
    ic_req = 1'b0;
    bus_valid = 1'b1; bus_rdata = BEEF;
    tick();
    bus_valid = 1'b0;
    check("post rst done", W'(ic_done), 1);
    // bus_valid in IDLE with no requests
    bus_valid = 1'b1; bus_rdata = DLINE;
    tick();
    tick();
    bus_valid = 1'b0;
    check("idle valid req", W'(bus_req), 0);
    check("idle valid dones", W'({ic_done, dc_done}), 0);
    check("idle valid ic_data", ic_data, BEEF);
    check("idle valid dc_data", dc_data, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter BUS_ADDRESS_WIDTH, default 20, byte-address width of the external memory bus.
REQ-002 SHALL have parameter BUS_DATA_WIDTH_SHIFT, default 4; the bus line is (2**BUS_DATA_WIDTH_SHIFT)*8 = 128 bits, denoted W; A = BUS_ADDRESS_WIDTH-BUS_DATA_WIDTH_SHIFT, the line-address width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ic_req_i, input, 1, instruction-cache refill request (read only).
REQ-006 SHALL have port ic_addr_i, input, A, instruction-cache line address.
REQ-007 SHALL have port ic_done_o, output, 1, one-cycle pulse when ic_data_o holds the completed read line.
REQ-008 SHALL have port ic_data_o, output, W, read line for the instruction cache.
REQ-009 SHALL have port dc_req_i, input, 1, data-cache request.
REQ-010 SHALL have port dc_we_i, input, 1, data-cache request is a write (1) or read (0).
REQ-011 SHALL have port dc_addr_i, input, A, data-cache line address.
REQ-012 SHALL have port dc_wdata_i, input, W, data-cache write line.
REQ-013 SHALL have port dc_done_o, output, 1, one-cycle pulse when the data-cache transaction has completed.
REQ-014 SHALL have port dc_data_o, output, W, read line for the data cache.
REQ-015 SHALL have port bus_req_o, output, 1, a bus transaction is outstanding.
REQ-016 SHALL have port bus_addr_o, output, A, bus line address.
REQ-017 SHALL have port bus_data_o, output, W, bus write line.
REQ-018 SHALL have port bus_we_o, output, 1, bus write enable.
REQ-019 SHALL have port bus_data_i, input, W, bus read line.
REQ-020 SHALL have port bus_valid_i, input, 1, bus completion strobe for reads and writes alike.

Function
REQ-021 SHALL implement the states IDLE, GRANT_IC and GRANT_DC.
REQ-022 In IDLE with at least one request asserted, SHALL select a winner per REQ-030, enter its GRANT state next cycle, and register that requester's address, write line and write flag.
REQ-023 In either GRANT state, bus_req_o, bus_addr_o, bus_data_o and bus_we_o SHALL be driven from the registered values and held stable until completion.
REQ-024 bus_we_o SHALL be 0 in GRANT_IC; bus_data_o SHALL be 0 whenever bus_we_o is 0.
REQ-025 In a GRANT state with bus_valid_i=1, SHALL pulse the owner's done for exactly one cycle, register bus_data_i into the owner's data output on reads, and return to IDLE; minimum latency from request to done is 2 cycles.
REQ-026 ic_data_o and dc_data_o SHALL hold their last read line until the next read completion for that requester.
REQ-027 bus_valid_i SHALL be ignored in IDLE.
REQ-028 Deassertion of the owner's request mid-transaction SHALL NOT abort it; the transaction completes and done still pulses.
REQ-029 A request asserted on the cycle its own done pulses SHALL be evaluated in the following IDLE cycle; each transaction passes through IDLE for at least one cycle.
REQ-030 Arbitration SHALL be as set by REQ-035/REQ-036; with a single request asserted, that requester always wins.

Reset
REQ-031 While rst_i=0, the state SHALL be IDLE and all outputs SHALL be 0, including ic_data_o and dc_data_o.
REQ-032 Reset asserted mid-transaction SHALL abandon it immediately with no done pulse; the requester must re-request.
REQ-033 After rst_i rises, SHALL arbitrate on the first rising clock edge.
REQ-034 The round-robin pointer SHALL reset to "instruction cache has priority".

Configuration
REQ-035 With macro BUS_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted alternately: priority goes to the requester that did not win the previous grant.
REQ-036 Without BUS_ARB_ROUND_ROBIN_EN, the data cache SHALL have fixed priority over the instruction cache.

Verification
REQ-037 IC read, addr 0x0040, bus_valid_i 3 cycles after bus_req_o with data 0x...DEADBEEF -> bus_we_o=0, ic_done_o pulses once, ic_data_o=0x...DEADBEEF held afterwards.
REQ-038 DC write, addr 0x0FFFF (all ones), wdata 0x1234... -> bus_addr_o=0x0FFFF and bus_data_o=0x1234... stable until valid, bus_we_o=1, dc_done_o pulses, dc_data_o unchanged.
REQ-039 Both requests asserted continuously, 4 transactions -> round-robin build grants IC,DC,IC,DC; fixed build grants DC four times and IC is starved.
REQ-040 rst_i driven low 1 cycle into GRANT_DC, then released -> outputs 0 asynchronously, no dc_done_o pulse, next grant starts from IDLE.
REQ-041 bus_valid_i pulsed in IDLE with no requests, and ic_req_i dropped mid-GRANT_IC -> no state change in IDLE; IC transaction still completes with one ic_done_o pulse.
